// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the single write port of an async FIFO among
// NUM_REQ producers in the write clock domain. One producer is granted at a
// time for a burst of at most BURST_MAX beats. Under afull each grant is cut
// to a single beat so every active producer keeps getting access.
//
// Ports:
//   clk        write-domain clock (same as the FIFO wclk)
//   rst        asynchronous active-high reset
//   req_valid  per-requester data valid
//   req_data   requester i data in bits [i*DW +: DW]
//   req_ready  per-requester accept, one-hot or zero
//   wfull      FIFO full flag
//   afull      FIFO almost-full flag
//   winc       FIFO write enable
//   wdata      FIFO write data (mux of req_data by gnt_id)
//   gnt_id     current or last granted requester
//   busy       high while a grant is held
//   stall      granted requester has data but the FIFO is full
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       wfull,
  input  logic                       afull,
  output logic                       winc,
  output logic [DW-1:0]              wdata,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       stall
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] CNT_LAST = BW'(BURST_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]   last_ptr_q, last_ptr_d;

  logic            in_grant_s;
  logic            gnt_valid_s;
  logic            beat_s;
  logic            sel_found_s;
  logic [IW-1:0]   sel_id_s;
  logic [DW-1:0]   data_arr_s [NUM_REQ];

  // Unpack the flat request data bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = req_data[g*DW +: DW];
  end

  assign in_grant_s  = (state_q == ST_GRANT);
  assign gnt_valid_s = req_valid[gnt_id_q];
  // A beat is a completed handshake with the granted requester.
  assign beat_s      = in_grant_s & gnt_valid_s & ~wfull;

  assign winc   = beat_s;
  assign wdata  = data_arr_s[gnt_id_q];
  assign gnt_id = gnt_id_q;
  assign busy   = in_grant_s;
  assign stall  = in_grant_s & gnt_valid_s & wfull;

  // Ready goes only to the granted requester and only while the FIFO has room.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = in_grant_s & (gnt_id_q == IW'(i)) & ~wfull;
    end
  end

  // Round-robin search: first valid requester after last_ptr, wrapping.
  always_comb begin
    logic [IW-1:0] idx;
    sel_found_s = 1'b0;
    sel_id_s    = {IW{1'b0}};
    idx         = {IW{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_ptr_q) + k) % NUM_REQ);
      if (!sel_found_s && req_valid[idx]) begin
        sel_found_s = 1'b1;
        sel_id_s    = idx;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state logic for the grant FSM and its bookkeeping registers.
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = beat_cnt_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_d    = ST_GRANT;
          gnt_id_d   = sel_id_s;
          last_ptr_d = sel_id_s;
          beat_cnt_d = {BW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!gnt_valid_s) begin
          // Requester withdrew; nothing was handed over, so nothing is lost.
          state_d = ST_IDLE;
        end else if (beat_s && ((beat_cnt_q == CNT_LAST) || afull)) begin
          state_d = ST_IDLE;
        end else if (beat_s) begin
          beat_cnt_d = beat_cnt_q + BW'(1'b1);
        end else begin
          // FIFO full: hold the grant with no timeout.
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= {IW{1'b0}};
      beat_cnt_q <= {BW{1'b0}};
      last_ptr_q <= LAST_RST;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DW=8, BURST_MAX=4).
// Producers are modelled as per-requester data lists; a behavioural model
// of the grant rules predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            wfull = 1'b0;
  logic            afull = 1'b0;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            stall;

  int checks = 0;
  int errors = 0;

  // producer data lists
  logic [7:0] mem [NR][64];
  int         hd [NR];
  int         tl [NR];
  bit         en [NR];

  // behavioural model state
  bit   m_busy;
  int   m_gid;
  int   m_cnt;
  int   m_last;
  logic [8:0] e_vec;
  logic [7:0] e_wdata;

  // observed write log
  int         cyc;
  int         log_gid [$];
  logic [7:0] log_dat [$];
  int         log_cyc [$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DW(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .afull(afull), .winc(winc),
    .wdata(wdata), .gnt_id(gnt_id), .busy(busy), .stall(stall)
  );

  always @(negedge clk) begin
    if (!rst && winc) begin
      log_gid.push_back(int'(gnt_id));
      log_dat.push_back(wdata);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic void model_reset();
    m_busy = 1'b0;
    m_gid  = 0;
    m_cnt  = 0;
    m_last = NR - 1;
  endfunction

  function automatic void model_eval();
    logic [3:0] rdy;
    bit bt, st;
    rdy = 4'b0000;
    if (m_busy && !wfull) rdy[m_gid] = 1'b1;
    bt = m_busy && req_valid[m_gid] && !wfull;
    st = m_busy && req_valid[m_gid] && wfull;
    e_vec   = {bt, rdy, m_busy, st, 2'(m_gid)};
    e_wdata = mem[m_gid][hd[m_gid]];
  endfunction

  // Apply the clock edge to the model: pop accepted data, then the grant rules.
  function automatic void model_advance();
    bit bt;
    int sel;
    bt = m_busy && req_valid[m_gid] && !wfull;
    if (bt) hd[m_gid]++;
    if (!m_busy) begin
      sel = -1;
      for (int k = 1; k <= NR; k++)
        if (sel < 0 && req_valid[(m_last + k) % NR]) sel = (m_last + k) % NR;
      if (sel >= 0) begin
        m_busy = 1'b1; m_gid = sel; m_last = sel; m_cnt = 0;
      end
    end else if (!req_valid[m_gid]) begin
      m_busy = 1'b0;
    end else if (bt) begin
      m_cnt++;
      if (m_cnt == BM || afull) m_busy = 1'b0;
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (hd[i] < tl[i]);
      req_data[i*DW +: DW] = (hd[i] < tl[i]) ? mem[i][hd[i]] : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    cyc++;
    #1;
  endtask

  task automatic fill(input int i, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) mem[i][j] = base + 8'(j);
    hd[i] = 0;
    tl[i] = n;
    en[i] = 1'b1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    log_gid.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wfull = 1'b0;
    afull = 1'b0;
    for (int i = 0; i < NR; i++) begin en[i] = 1'b0; hd[i] = 0; tl[i] = 0; end
    drive();
    model_reset();
    @(posedge clk);
    release_rst();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < NR; i++) fill(i, 8, 8'(16 * i));
    drive();
    #2;
    checks++;
    if ({winc, req_ready, busy, stall, gnt_id} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {winc, req_ready, busy, stall, gnt_id}, 9'b0);
    end
    checks++;
    if (wdata !== req_data[7:0]) begin
      errors++;
      $display("FAIL reset_wdata got=%h exp=%h", wdata, req_data[7:0]);
    end
    @(negedge clk);
    checks++;
    if ({winc, req_ready, busy, stall, gnt_id} !== 9'b0) begin
      errors++;
      $display("FAIL reset_after_edge got=%b exp=%b", {winc, req_ready, busy, stall, gnt_id}, 9'b0);
    end
    release_rst();
    for (int c = 0; c < 3; c++) begin
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL reset_ctl cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      tick();
    end
    checks++;
    if (log_gid.size() == 0 || log_gid[0] != 0) begin
      errors++;
      $display("FAIL reset_first_grant got=%0d exp=0", log_gid.size() ? log_gid[0] : -1);
    end
  endtask

  task automatic test_single();
    do_reset();
    fill(2, 6, 8'hA0);
    for (int c = 0; c < 10; c++) begin
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL single_ctl cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      if (e_vec[8]) begin
        checks++;
        if (wdata !== e_wdata) begin
          errors++;
          $display("FAIL single_data cyc=%0d got=%h exp=%h", cyc, wdata, e_wdata);
        end
      end
      tick();
    end
    checks++;
    if (log_dat.size() != 6) begin
      errors++;
      $display("FAIL single_count got=%0d exp=6", log_dat.size());
    end
    for (int j = 0; j < 6 && j < log_dat.size(); j++) begin
      checks++;
      if (log_dat[j] !== 8'hA0 + 8'(j) || log_gid[j] != 2 || log_cyc[j] != (j < 4 ? j + 1 : j + 2)) begin
        errors++;
        $display("FAIL single_beat%0d got=%h/id%0d/c%0d exp=%h/id2/c%0d", j, log_dat[j], log_gid[j],
                 log_cyc[j], 8'hA0 + 8'(j), (j < 4 ? j + 1 : j + 2));
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NR; i++) fill(i, 16, 8'(16 * i));
    for (int c = 0; c < 25; c++) begin
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL fair_ctl cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      tick();
    end
    checks++;
    if (log_gid.size() != 20) begin
      errors++;
      $display("FAIL fair_count got=%0d exp=20", log_gid.size());
    end
    for (int j = 0; j < 20 && j < log_gid.size(); j++) begin
      checks++;
      if (log_gid[j] != (j / 4) % 4 || log_cyc[j] != (j / 4) * 5 + j % 4 + 1) begin
        errors++;
        $display("FAIL fair_beat%0d got=id%0d/c%0d exp=id%0d/c%0d", j, log_gid[j], log_cyc[j],
                 (j / 4) % 4, (j / 4) * 5 + j % 4 + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill(0, 4, 8'h10);
    for (int c = 0; c < 10; c++) begin
      wfull = (c >= 3 && c <= 5);
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL bp_ctl cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      if (wfull) begin
        checks++;
        if ({winc, req_ready, stall} !== 6'b000001) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d got=%b exp=000001", cyc, {winc, req_ready, stall});
        end
      end
      tick();
    end
    wfull = 1'b0;
    checks++;
    if (log_dat.size() != 4) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=4", log_dat.size());
    end
    for (int j = 0; j < 4 && j < log_dat.size(); j++) begin
      checks++;
      if (log_dat[j] !== 8'h10 + 8'(j) || log_cyc[j] != (j < 2 ? j + 1 : j + 4)) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h/c%0d exp=%h/c%0d", j, log_dat[j], log_cyc[j],
                 8'h10 + 8'(j), (j < 2 ? j + 1 : j + 4));
      end
    end
  endtask

  task automatic test_afull();
    do_reset();
    fill(1, 16, 8'h40);
    fill(3, 16, 8'h80);
    afull = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec || winc !== c[0]) begin
        errors++;
        $display("FAIL afull_ctl cyc=%0d got=%b exp=%b winc_exp=%b", cyc,
                 {winc, req_ready, busy, stall, gnt_id}, e_vec, c[0]);
      end
      tick();
    end
    afull = 1'b0;
    checks++;
    if (log_gid.size() != 6) begin
      errors++;
      $display("FAIL afull_count got=%0d exp=6", log_gid.size());
    end
    for (int j = 0; j < 6 && j < log_gid.size(); j++) begin
      checks++;
      if (log_gid[j] != (j % 2 == 0 ? 1 : 3)) begin
        errors++;
        $display("FAIL afull_order%0d got=%0d exp=%0d", j, log_gid[j], (j % 2 == 0 ? 1 : 3));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill(1, 8, 8'h50);
    for (int c = 0; c < 4; c++) begin
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL midrst_ctl cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      if (c < 3) tick();
    end
    // cycle 3 carries the 3rd beat; reset lands before its clock edge
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({winc, busy, req_ready} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_drop got=%b exp=000000", {winc, busy, req_ready});
    end
    model_reset();
    @(posedge clk);
    fill(0, 4, 8'h60);
    drive();
    release_rst();
    for (int c = 0; c < 8; c++) begin
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL midrst_after cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      if (e_vec[8]) begin
        checks++;
        if (wdata !== e_wdata) begin
          errors++;
          $display("FAIL midrst_data cyc=%0d got=%h exp=%h", cyc, wdata, e_wdata);
        end
      end
      tick();
    end
    checks++;
    if (log_gid.size() < 5 || log_gid[0] != 0 || log_dat[4] !== 8'h52) begin
      errors++;
      $display("FAIL midrst_regrant got=%0d/%h exp=0/52", log_gid.size() ? log_gid[0] : -1,
               log_dat.size() > 4 ? log_dat[4] : 8'h00);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NR; i++) begin
      tl[i] = $urandom_range(0, 40);
      for (int j = 0; j < 64; j++) mem[i][j] = 8'($urandom);
      en[i] = 1'b1;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 15) == 0) en[i] = !en[i];
      wfull = ($urandom_range(0, 3) == 0);
      afull = ($urandom_range(0, 3) == 0);
      drive(); @(negedge clk); model_eval(); checks++;
      if ({winc, req_ready, busy, stall, gnt_id} !== e_vec) begin
        errors++;
        $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", cyc, {winc, req_ready, busy, stall, gnt_id}, e_vec);
      end
      if (e_vec[8]) begin
        checks++;
        if (wdata !== e_wdata) begin
          errors++;
          $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, wdata, e_wdata);
        end
      end
      tick();
    end
    wfull = 1'b0;
    afull = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin en[i] = 1'b0; hd[i] = 0; tl[i] = 0; end
    cyc = 0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_afull();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
